// File: rtl/mcp3208_pkg.sv
// Shared definitions for the MCP3208 ADC emulator: FSM state codes, result
// and channel sizing, output bit positions and the result helpers.
// Optional build macro: MCP3208_LSBF_EN (LSB-first repeat after B0).
package mcp3208_pkg;

  // Result width and channel sizing
  localparam int RESULT_W   = 12;
  localparam int CHAN_COUNT = 8;
  localparam int CHAN_W     = 3;

  // Width of the shared command/bit-position counter
  localparam int POS_W = 5;

  // Frame state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_CMD    = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_TAIL   = 3'd5;

  // Index of the last command rise after the start bit (R1..R4 -> 0..3)
  localparam logic [POS_W-1:0] CMD_LAST = 5'd3;

  // Output bit positions, counted in sclk falls from the null bit at F5:
  // position 0 is the null bit, 1..12 carry B11..B0, 13..23 carry B1..B11.
  localparam logic [POS_W-1:0] POS_NULL      = 5'd0;
  localparam logic [POS_W-1:0] POS_MSB_FIRST = 5'd1;
  localparam logic [POS_W-1:0] POS_MSB_LAST  = 5'd12;
  localparam logic [POS_W-1:0] POS_LSB_LAST  = 5'd23;

  typedef logic [RESULT_W-1:0] sample_t;

  // Pseudo-differential result: positive input minus negative input,
  // with anything below zero reported as zero code.
  function automatic sample_t diff_clamp(input sample_t pos_in, input sample_t neg_in);
    logic signed [RESULT_W:0] diff;
    diff = $signed({1'b0, pos_in}) - $signed({1'b0, neg_in});
    return diff[RESULT_W] ? '0 : diff[RESULT_W-1:0];
  endfunction

  // Result bit that belongs on dout at a given output position.
  function automatic logic bit_at(input sample_t value, input logic [POS_W-1:0] pos);
    logic [3:0] idx;
    logic       b;
    b   = 1'b0;
    idx = 4'd0;
    if (pos >= POS_MSB_FIRST && pos <= POS_MSB_LAST) begin
      idx = 4'(POS_MSB_LAST - pos);
      b   = value[idx];
    end else if (pos > POS_MSB_LAST && pos <= POS_LSB_LAST) begin
      idx = 4'(pos - POS_MSB_LAST);
      b   = value[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous SPI pin.
// Edges are only reported once the chain and the edge register hold real
// samples, so the reset value never shows up as a phantom edge.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   filled;

  // Shift the pin through the flop chain and remember the previous level
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= {STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
      filled <= '0;
    end else begin
      chain  <= {chain[STAGES-2:0], async_in};
      prev   <= chain[STAGES-1];
      filled <= {filled[STAGES-1:0], 1'b1};
    end
  end

  // Level and qualified single-cycle edge strobes
  always_comb begin
    level = chain[STAGES-1];
    rise  = filled[STAGES] & chain[STAGES-1] & ~prev;
    fall  = filled[STAGES] & ~chain[STAGES-1] & prev;
  end

endmodule

// File: rtl/mcp3208_emu.sv
// MCP3208 12-bit 8-channel SPI ADC emulator. The host loads the channel
// values; an SPI master reads them back with the standard MCP3208 frame.
// Optional build macro: MCP3208_LSBF_EN repeats B1..B11 LSB-first after B0.
module mcp3208_emu
  import mcp3208_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                cs_n,
  input  logic                sclk,
  input  logic                din,
  output logic                dout,
  output logic                dout_oe,
  input  logic                wr_en,
  input  logic [CHAN_W-1:0]   wr_addr,
  input  logic [RESULT_W-1:0] wr_data,
  output logic                frame_done,
  output logic [CHAN_W-1:0]   frame_chan,
  output logic                frame_sgl,
  output logic                frame_err
);

`ifdef MCP3208_LSBF_EN
  localparam logic [POS_W-1:0] POS_DATA_LAST = POS_LSB_LAST;
`else
  localparam logic [POS_W-1:0] POS_DATA_LAST = POS_MSB_LAST;
`endif

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic din_level, din_rise, din_fall;
  logic unused_edges;

  sample_t chan_reg [CHAN_COUNT];

  logic [2:0]        state;
  logic [POS_W-1:0]  cnt;
  logic [2:0]        cmd_bits;
  logic              cmd_valid;
  logic              cmd_sgl;
  logic [CHAN_W-1:0] cmd_chan;
  sample_t           result;

  logic [CHAN_W-1:0] r4_chan;
  sample_t           r4_value;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock    (clock),
    .rst_n    (rst_n),
    .async_in (cs_n),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock    (clock),
    .rst_n    (rst_n),
    .async_in (sclk),
    .level    (sclk_level),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clock    (clock),
    .rst_n    (rst_n),
    .async_in (din),
    .level    (din_level),
    .rise     (din_rise),
    .fall     (din_fall)
  );

  assign unused_edges = ^{cs_rise, sclk_level, din_rise, din_fall};

  // Host-side channel value registers, writable at any time
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHAN_COUNT; i++) begin
        chan_reg[i] <= '0;
      end
    end else if (wr_en) begin
      chan_reg[wr_addr] <= wr_data;
    end
  end

  // Conversion result as it would be latched on the fourth command rise
  always_comb begin
    r4_chan  = {cmd_bits[1:0], din_level};
    r4_value = cmd_bits[2] ? chan_reg[r4_chan]
                           : diff_clamp(chan_reg[r4_chan], chan_reg[r4_chan ^ 3'd1]);
  end

  // Frame sequencer: command capture, result shift-out and frame reporting
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cmd_bits   <= '0;
      cmd_valid  <= 1'b0;
      cmd_sgl    <= 1'b0;
      cmd_chan   <= '0;
      result     <= '0;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      frame_done <= 1'b0;
      frame_chan <= '0;
      frame_sgl  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_level && state != ST_IDLE) begin
        state   <= ST_IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
        if (state != ST_START) begin
          frame_done <= 1'b1;
          frame_chan <= cmd_valid ? cmd_chan : '0;
          frame_sgl  <= cmd_valid & cmd_sgl;
          frame_err  <= (state != ST_TAIL);
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state     <= ST_START;
              cnt       <= '0;
              cmd_bits  <= '0;
              cmd_valid <= 1'b0;
            end
          end
          ST_START: begin
            if (sclk_rise && din_level) begin
              state <= ST_CMD;
              cnt   <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_bits <= {cmd_bits[1:0], din_level};
              if (cnt == CMD_LAST) begin
                result    <= r4_value;
                cmd_sgl   <= cmd_bits[2];
                cmd_chan  <= r4_chan;
                cmd_valid <= 1'b1;
                cnt       <= POS_NULL;
                state     <= ST_SAMPLE;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          ST_SAMPLE: begin
            if (sclk_rise) begin
              cnt <= POS_MSB_FIRST;
            end else if (sclk_fall && cnt == POS_MSB_FIRST) begin
              dout    <= 1'b0;
              dout_oe <= 1'b1;
              state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              dout <= bit_at(result, cnt);
              if (cnt == POS_DATA_LAST) begin
                state <= ST_TAIL;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          ST_TAIL: begin
            if (sclk_fall) begin
              dout <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            dout    <= 1'b0;
            dout_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3208_emu.sv
// Self-checking bench for mcp3208_emu: a simple SPI master plus a channel
// value model predicting each conversion result from the ADC's rules.
// Honours MCP3208_LSBF_EN for the LSB-first repeat after B0.
`timescale 1ns/1ps
module tb_mcp3208_emu;

  localparam int SYNC = 2;
  localparam int HALF = 5;
`ifdef MCP3208_LSBF_EN
  localparam int TAIL_FIRST = 30;
`else
  localparam int TAIL_FIRST = 19;
`endif
  localparam int FULL_RISES = TAIL_FIRST + 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic        din = 1'b0;
  logic        dout;
  logic        dout_oe;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [11:0] wr_data = 12'd0;
  logic        frame_done;
  logic [2:0]  frame_chan;
  logic        frame_sgl;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  int ch_model [8];

  int         done_pulses = 0;
  logic [2:0] seen_chan = 3'd0;
  logic       seen_sgl = 1'b0;
  logic       seen_err = 1'b0;

  logic        samp_dout [0:40];
  logic        samp_oe   [0:40];
  logic        cap_null;
  logic [11:0] cap_msb;
  logic [10:0] cap_lsb;
  logic        cap_tail;
  logic [1:0]  cap_oe;

  mcp3208_emu #(.SYNC_STAGES(SYNC)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_chan (frame_chan),
    .frame_sgl  (frame_sgl),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  // Count every cycle frame_done is high and keep the reported command
  always @(negedge clock) begin
    if (frame_done === 1'b1) begin
      done_pulses++;
      seen_chan = frame_chan;
      seen_sgl  = frame_sgl;
      seen_err  = frame_err;
    end
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic int expect_value(input bit sgl, input int chan);
    int d;
    if (sgl) return ch_model[chan];
    d = ch_model[chan] - ch_model[chan ^ 1];
    return (d < 0) ? 0 : d;
  endfunction

  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [11:0] data);
    wr_addr = addr;
    wr_data = data;
    wr_en   = 1'b1;
    wait_clocks(1);
    wr_en   = 1'b0;
    ch_model[addr] = int'(data);
  endtask

  // SPI master: sends a command and samples dout just before every sclk rise
  task automatic spi_frame(input int lead, input bit sgl, input int chan, input int last_rise,
                           input bit late_wr, input logic [11:0] late_val);
    int   k;
    logic b;
    for (int i = 0; i <= 40; i++) begin
      samp_dout[i] = 1'b0;
      samp_oe[i]   = 1'b0;
    end
    cs_n = 1'b0;
    wait_clocks(4);
    for (int i = 0; i <= lead + last_rise; i++) begin
      k = i - lead;
      if (k < 0)       b = 1'b0;
      else if (k == 0) b = 1'b1;
      else if (k == 1) b = sgl;
      else if (k <= 4) b = chan[4-k];
      else             b = 1'($urandom_range(0, 1));
      din = b;
      wait_clocks(HALF);
      if (k >= 0) begin
        samp_dout[k] = dout;
        samp_oe[k]   = dout_oe;
      end
      sclk = 1'b1;
      if (late_wr && k == 6) begin
        host_write(3'(chan), late_val);
        wait_clocks(HALF - 1);
      end else begin
        wait_clocks(HALF);
      end
      sclk = 1'b0;
    end
    wait_clocks(HALF);
    cap_null = samp_dout[6];
    for (int j = 0; j < 12; j++) cap_msb[11-j] = samp_dout[7+j];
    for (int j = 0; j < 11; j++) cap_lsb[j] = samp_dout[19+j];
    cap_tail = 1'b0;
    for (int j = TAIL_FIRST; j <= last_rise; j++) cap_tail = cap_tail | samp_dout[j];
    cap_oe = 2'b01;
    for (int j = 0; j <= 5; j++) cap_oe[1] = cap_oe[1] | samp_oe[j];
    for (int j = 6; j <= last_rise; j++) cap_oe[0] = cap_oe[0] & samp_oe[j];
  endtask

  // Complete frame ending after the data phase, checked against the model
  task automatic test_full_frame(input string name, input int lead, input bit sgl, input int chan,
                                 input bit late_wr, input logic [11:0] late_val);
    logic [11:0] exp;
    int          pulses;
    exp    = 12'(expect_value(sgl, chan));
    pulses = done_pulses;
    spi_frame(lead, sgl, chan, FULL_RISES, late_wr, late_val);
    cs_n = 1'b1;
    wait_clocks(SYNC + 4);
    n_cmp++;
    if ({cap_null, cap_msb} !== {1'b0, exp}) begin
      n_bad++;
      $display("[TB] FAIL %s null+data: got %b_%h want 0_%h", name, cap_null, cap_msb, exp);
    end
    n_cmp++;
    if (cap_oe !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL %s dout_oe window: got %b want 01", name, cap_oe);
    end
    n_cmp++;
    if (cap_tail !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s tail dout: got %b want 0", name, cap_tail);
    end
`ifdef MCP3208_LSBF_EN
    n_cmp++;
    if (cap_lsb !== exp[11:1]) begin
      n_bad++;
      $display("[TB] FAIL %s lsb-first: got %b want %b", name, cap_lsb, exp[11:1]);
    end
`endif
    n_cmp++;
    if (done_pulses - pulses != 1) begin
      n_bad++;
      $display("[TB] FAIL %s frame_done cycles: got %0d want 1", name, done_pulses - pulses);
    end
    n_cmp++;
    if ({seen_chan, seen_sgl, seen_err} !== {3'(chan), sgl, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL %s chan/sgl/err: got %0d/%b/%b want %0d/%b/0",
               name, seen_chan, seen_sgl, seen_err, chan, sgl);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({dout, dout_oe, frame_done, frame_chan, frame_sgl, frame_err} !== 8'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_hold outputs: got %b want 0", {dout, dout_oe, frame_done, frame_chan, frame_sgl, frame_err});
    end
    wait_clocks(3);
    rst_n = 1'b1;
    wait_clocks(6);
    n_cmp++;
    if ({dout, dout_oe} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL reset_release dout/oe: got %b want 00", {dout, dout_oe});
    end
    n_cmp++;
    if ({frame_chan, frame_sgl, frame_err} !== 5'd0 || done_pulses != 0) begin
      n_bad++;
      $display("[TB] FAIL reset_release frame: got %b pulses %0d want 0", {frame_chan, frame_sgl, frame_err}, done_pulses);
    end
  endtask

  task automatic test_single_ended();
    host_write(3'd3, 12'hA5C);
    test_full_frame("single_ch3", 0, 1'b1, 3, 1'b0, 12'h0);
    n_cmp++;
    if (cap_msb !== 12'hA5C) begin
      n_bad++;
      $display("[TB] FAIL single_ch3 literal: got %h want a5c", cap_msb);
    end
  endtask

  task automatic test_differential();
    host_write(3'd4, 12'h300);
    host_write(3'd5, 12'h100);
    test_full_frame("diff_ch4", 0, 1'b0, 4, 1'b0, 12'h0);
    n_cmp++;
    if (cap_msb !== 12'h200) begin
      n_bad++;
      $display("[TB] FAIL diff_ch4 literal: got %h want 200", cap_msb);
    end
    test_full_frame("diff_ch5", 0, 1'b0, 5, 1'b0, 12'h0);
    n_cmp++;
    if (cap_msb !== 12'h000) begin
      n_bad++;
      $display("[TB] FAIL diff_ch5 clamp: got %h want 000", cap_msb);
    end
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    int          pulses;
    host_write(3'd2, 12'(12'h400 | $urandom_range(0, 12'h3FF)));
    host_write(3'd3, 12'(12'h100 + $urandom_range(0, 12'h0FF)));
    exp    = 12'(expect_value(1'b0, 2));
    pulses = done_pulses;
    spi_frame(0, 1'b0, 2, 12, 1'b0, 12'h0);
    n_cmp++;
    if ({dout_oe, cap_msb[11:6]} !== {1'b1, exp[11:6]}) begin
      n_bad++;
      $display("[TB] FAIL abort partial: got oe %b bits %b want oe 1 bits %b", dout_oe, cap_msb[11:6], exp[11:6]);
    end
    cs_n = 1'b1;
    repeat (SYNC + 1) @(posedge clock);
    #1;
    n_cmp++;
    if ({dout_oe, dout} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL abort release oe/dout: got %b want 00", {dout_oe, dout});
    end
    wait_clocks(6);
    n_cmp++;
    if (done_pulses - pulses != 1 || {seen_chan, seen_sgl, seen_err} !== {3'd2, 1'b0, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL abort report: got %0d pulses %0d/%b/%b want 1 pulse 2/0/1",
               done_pulses - pulses, seen_chan, seen_sgl, seen_err);
    end
    test_full_frame("after_abort", 0, 1'b0, 2, 1'b0, 12'h0);
  endtask

  task automatic test_leading_zeros();
    int   pulses;
    logic oe_seen;
    host_write(3'd7, 12'($urandom_range(0, 12'hFFF)));
    test_full_frame("lead3_ch7", 3, 1'b1, 7, 1'b0, 12'h0);
    pulses  = done_pulses;
    oe_seen = 1'b0;
    cs_n    = 1'b0;
    din     = 1'b0;
    wait_clocks(4);
    for (int i = 0; i < 8; i++) begin
      wait_clocks(HALF);
      sclk = 1'b1;
      wait_clocks(HALF);
      sclk = 1'b0;
      oe_seen = oe_seen | dout_oe;
    end
    cs_n = 1'b1;
    wait_clocks(SYNC + 4);
    n_cmp++;
    if (done_pulses - pulses != 0 || oe_seen !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL no_start: got %0d pulses oe %b want 0 pulses oe 0", done_pulses - pulses, oe_seen);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    host_write(3'd1, 12'(12'h800 | $urandom_range(0, 12'h7FF)));
    spi_frame(0, 1'b1, 1, 12, 1'b0, 12'h0);
    n_cmp++;
    if (dout_oe !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_mid pre oe: got %b want 1", dout_oe);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dout, dout_oe, frame_done, frame_chan, frame_sgl, frame_err} !== 8'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid outputs: got %b want 0", {dout, dout_oe, frame_done, frame_chan, frame_sgl, frame_err});
    end
    for (int i = 0; i < 8; i++) ch_model[i] = 0;
    wait_clocks(3);
    rst_n = 1'b1;
    wait_clocks(10);
    pulses = done_pulses;
    cs_n = 1'b1;
    wait_clocks(SYNC + 4);
    n_cmp++;
    if (done_pulses - pulses != 0 || dout_oe !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid idle: got %0d pulses oe %b want 0 pulses oe 0", done_pulses - pulses, dout_oe);
    end
    test_full_frame("after_reset", 0, 1'b1, 1, 1'b0, 12'h0);
    n_cmp++;
    if (cap_msb !== 12'h000) begin
      n_bad++;
      $display("[TB] FAIL after_reset literal: got %h want 000", cap_msb);
    end
  endtask

  task automatic test_random();
    int chan;
    bit sgl;
    for (int n = 0; n < 10; n++) begin
      host_write(3'($urandom_range(0, 7)), 12'($urandom_range(0, 12'hFFF)));
      host_write(3'($urandom_range(0, 7)), 12'($urandom_range(0, 12'hFFF)));
      chan = int'($urandom_range(0, 7));
      sgl  = 1'($urandom_range(0, 1));
      test_full_frame($sformatf("random%0d", n), int'($urandom_range(0, 3)), sgl, chan,
                      1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'hFFF)));
    end
  endtask

`ifdef MCP3208_LSBF_EN
  task automatic test_lsbf();
    host_write(3'd0, 12'h801);
    test_full_frame("lsbf_ch0", 0, 1'b1, 0, 1'b0, 12'h0);
    n_cmp++;
    if ({cap_msb, cap_lsb} !== {12'h801, 11'b100_0000_0000}) begin
      n_bad++;
      $display("[TB] FAIL lsbf literal: got %h %b want 801 10000000000", cap_msb, cap_lsb);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) ch_model[i] = 0;
    test_reset();
    test_single_ended();
    test_differential();
    test_abort();
    test_leading_zeros();
    test_reset_mid();
    test_random();
`ifdef MCP3208_LSBF_EN
    test_lsbf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
